// File: rtl/key_enc_pkg.sv
// Shared types, sizes and the one-hot encode helper for the key encoder.
package key_enc_pkg;

    localparam int unsigned NUM_KEYS = 10;
    localparam int unsigned CODE_W   = 4;
    localparam logic [CODE_W-1:0] ERR_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        RELEASE
    } state_t;

    typedef struct packed {
        logic              err;
        logic [CODE_W-1:0] code;
    } enc_t;

    // Anything other than exactly one set bit encodes as ERR_CODE with err set.
    function automatic enc_t encode_onehot(input logic [NUM_KEYS-1:0] keys);
        enc_t        res;
        int unsigned ones;
        ones     = 0;
        res.err  = 1'b0;
        res.code = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) begin
                ones     = ones + 1;
                res.code = CODE_W'(i);
            end
        end
        if (ones != 1) begin
            res.err  = 1'b1;
            res.code = ERR_CODE;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser with synchronous active-high reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/onehot_key_encoder.sv
// Debounced 10-to-4 key encoder; one valid/ready event per press, error code on multi-hot.
module onehot_key_encoder
    import key_enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [NUM_KEYS-1:0] iKEY,
    output logic [CODE_W-1:0]   oCODE,
    output logic                oERR,
    output logic                oVALID,
    input  logic                iREADY
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_KEYS-1:0] s;
    state_t              state_q;
    logic [NUM_KEYS-1:0] cand_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_inc;
    enc_t                enc;

    sync_2ff #(
        .WIDTH(NUM_KEYS)
    ) u_sync (
        .clk_i(iCLK),
        .rst_i(iRST),
        .d_i  (iKEY),
        .q_o  (s)
    );

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign enc     = encode_onehot(cand_q);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            oCODE   <= '0;
            oERR    <= 1'b0;
            oVALID  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s != '0) begin
                        cand_q  <= s;
                        cnt_q   <= CNT_ONE;
                        state_q <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (s == cand_q) begin
                        if (cnt_q == CNT_LAST) begin
                            oCODE   <= enc.code;
                            oERR    <= enc.err;
                            oVALID  <= 1'b1;
                            state_q <= EMIT;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end else if (s == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cand_q <= s;
                        cnt_q  <= CNT_ONE;
                    end
                end
                EMIT: begin
                    // Key activity is deliberately ignored here: no queueing of events.
                    if (iREADY) begin
                        oVALID  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (s == '0) begin
                        cnt_q <= cnt_inc;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_key_encoder.sv
// Directed bench for onehot_key_encoder with DEBOUNCE_CYC=4.
module tb_onehot_key_encoder;
    import key_enc_pkg::*;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iREADY;
    logic [9:0] iKEY;
    logic [3:0] oCODE;
    logic       oERR;
    logic       oVALID;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 iCLK = ~iCLK;

    onehot_key_encoder #(
        .DEBOUNCE_CYC(4)
    ) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iKEY  (iKEY),
        .oCODE (oCODE),
        .oERR  (oERR),
        .oVALID(oVALID),
        .iREADY(iREADY)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic wait_valid(input int max_edges, output int edges);
        edges = 0;
        while (!oVALID && edges < max_edges) begin
            tick();
            edges++;
        end
    endtask

    task automatic run_quiet(input int cycles, input string tag);
        int seen;
        seen = 0;
        repeat (cycles) begin
            tick();
            if (oVALID) seen++;
        end
        check_eq(tag, seen, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        iRST   = 1'b1;
        iREADY = 1'b1;
        iKEY   = '0;
        tick();
        tick();
        iRST = 1'b0;
        check_eq("rst_valid", oVALID, 0);
        check_eq("rst_code", oCODE, 0);
        check_eq("rst_err", oERR, 0);
        check_eq("rst_idle", dut.state_q == IDLE, 1);

        // Clean press: valid after edge 6 for exactly one cycle.
        iKEY = 10'h008;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq("press_latency_low", oVALID, 0);
        end
        tick();
        check_eq("press_valid", oVALID, 1);
        check_eq("press_code", oCODE, 3);
        check_eq("press_err", oERR, 0);
        tick();
        check_eq("press_one_cycle", oVALID, 0);
        check_eq("press_code_kept", oCODE, 3);
        run_quiet(20, "held_no_repeat");
        iKEY = '0;
        repeat (5) tick();
        check_eq("release_not_yet_idle", dut.state_q == IDLE, 0);
        tick();
        check_eq("release_idle", dut.state_q == IDLE, 1);

        // Bounce on key 9.
        n = 0;
        for (int i = 0; i < 10; i++) begin
            iKEY = (((i / 2) % 2) == 0) ? 10'h200 : 10'h000;
            tick();
            if (oVALID) n++;
        end
        check_eq("bounce_quiet", n, 0);
        iKEY = 10'h200;
        wait_valid(20, n);
        check_eq("bounce_valid", oVALID, 1);
        check_eq("bounce_code", oCODE, 9);
        check_eq("bounce_err", oERR, 0);
        tick();
        iKEY = '0;
        repeat (8) tick();

        // Multi-hot.
        iKEY = 10'h011;
        wait_valid(20, n);
        check_eq("multi_valid", oVALID, 1);
        check_eq("multi_code", oCODE, 4'hF);
        check_eq("multi_err", oERR, 1);
        tick();
        iKEY = '0;
        repeat (8) tick();

        // Backpressure with a key change while holding.
        iREADY = 1'b0;
        iKEY   = 10'h004;
        wait_valid(20, n);
        check_eq("bp_code_first", oCODE, 2);
        iKEY = 10'h001;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_eq("bp_valid_held", oVALID, 1);
            check_eq("bp_code_held", oCODE, 2);
        end
        iREADY = 1'b1;
        tick();
        check_eq("bp_handshake", oVALID, 0);
        run_quiet(15, "bp_no_queue");
        iKEY = '0;
        repeat (8) tick();
        iKEY = 10'h001;
        wait_valid(20, n);
        check_eq("repress_valid", oVALID, 1);
        check_eq("repress_code", oCODE, 0);

        // Release glitch: zero run broken by a one-cycle pulse.
        tick();
        check_eq("glitch_handshake", oVALID, 0);
        n = 0;
        iKEY = '0;
        tick();
        tick();
        iKEY = 10'h004;
        tick();
        iKEY = '0;
        for (int k = 4; k <= 8; k++) begin
            tick();
            if (oVALID) n++;
            if (k == 6) check_eq("glitch_not_idle_a6", dut.state_q == IDLE, 0);
        end
        check_eq("glitch_not_idle_a8", dut.state_q == IDLE, 0);
        tick();
        check_eq("glitch_idle_a9", dut.state_q == IDLE, 1);
        check_eq("glitch_no_event", n, 0);

        // Reset while valid and ready are both high.
        iKEY = 10'h020;
        wait_valid(20, n);
        check_eq("pre_rst_code", oCODE, 5);
        iRST = 1'b1;
        iKEY = 10'h040;
        tick();
        iRST = 1'b0;
        check_eq("mid_rst_valid", oVALID, 0);
        check_eq("mid_rst_code", oCODE, 0);
        check_eq("mid_rst_err", oERR, 0);
        check_eq("mid_rst_idle", dut.state_q == IDLE, 1);
        wait_valid(20, n);
        check_eq("post_rst_latency", n, 6);
        check_eq("post_rst_code", oCODE, 6);
        check_eq("post_rst_err", oERR, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
